// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and the datapath.
// Carries the opcode/zero flag into the controller and every datapath
// enable and mux select back out. "master" is the controller side,
// "slave" is the datapath side.
interface multicycle_control_unit_if #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
);
  logic [OPW-1:0]    opcode;
  logic              zero;
  logic              PCWre;
  logic              IRWre;
  logic              InsMemRW;
  logic              RegWre;
  logic [1:0]        RegDst;
  logic              WrRegDSrc;
  logic              ExtSel;
  logic              ALUSrcA;
  logic              ALUSrcB;
  logic [ALUOPW-1:0] ALUOp;
  logic [1:0]        PCSrc;
  logic              mRD;
  logic              mWR;
  logic              DBDataSrc;

  modport master (
    input  opcode, zero,
    output PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ExtSel,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, mRD, mWR, DBDataSrc
  );

  modport slave (
    output opcode, zero,
    input  PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ExtSel,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, mRD, mWR, DBDataSrc
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the multicycle CPU. Sequences IF/ID/EXE/MEM/WB per
// opcode and drives every datapath enable and mux select combinationally
// from the registered state plus the opcode held in the IR.
// Optional feature macro: CU_PERF_COUNT_EN adds cycle_cnt / instr_cnt
// performance counters (absent in the default build).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IF      | fetch: load IR from instruction memory
// ID      | decode; j/jr/jal/undefined retire here
// EXE_AL  | ALU op for R-type / immediate instructions
// WB_AL   | write ALU result back to register file, retire
// EXE_BR  | beq compare (rs - rt), branch on zero, retire
// EXE_LS  | address calculation for lw/sw
// MEM     | data memory access; sw retires here
// WB_LD   | write load data back to register file, retire
// HALT    | stopped until reset
module multicycle_control_unit #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3,
  parameter int CNTW   = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
`ifdef CU_PERF_COUNT_EN
  output logic [CNTW-1:0]       cycle_cnt,
  output logic [CNTW-1:0]       instr_cnt,
`endif
  multicycle_control_unit_if.master bus
);

  if (CNTW < 1) begin : g_cntw_check
    $error("CNTW must be at least 1");
  end

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(6'b011000);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b100110);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
  localparam logic [OPW-1:0] OP_JR   = OPW'(6'b111001);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b111010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EXE_AL, S_WB_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_LD, S_HALT
  } state_t;

  state_t state, state_nxt;

  logic              pcwre, irwre, insmemrw, regwre, wrregdsrc, extsel;
  logic              alusrca, alusrcb, mrd, mwr, dbdatasrc;
  logic [1:0]        regdst, pcsrc;
  logic [ALUOPW-1:0] aluop;

  logic [ALUOPW-1:0] dec_aluop;
  logic              dec_srca, dec_srcb, dec_ext, dec_rtype, dec_alu;

  // State register; synchronous active-low reset returns to fetch
  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IF;
    else      state <= state_nxt;
  end

  // ALU-class decode shared by EXE_AL and WB_AL
  always_comb begin
    dec_aluop = '0;
    dec_srca  = 1'b0;
    dec_srcb  = 1'b0;
    dec_ext   = 1'b1;
    dec_rtype = 1'b1;
    dec_alu   = 1'b1;
    case (bus.opcode)
      OP_ADD:  dec_aluop = ALUOPW'(3'b000);
      OP_SUB:  dec_aluop = ALUOPW'(3'b001);
      OP_ADDI: begin
        dec_aluop = ALUOPW'(3'b000);
        dec_srcb  = 1'b1;
        dec_rtype = 1'b0;
      end
      OP_OR:   dec_aluop = ALUOPW'(3'b011);
      OP_AND:  dec_aluop = ALUOPW'(3'b100);
      OP_ORI:  begin
        dec_aluop = ALUOPW'(3'b011);
        dec_srcb  = 1'b1;
        dec_ext   = 1'b0;
        dec_rtype = 1'b0;
      end
      OP_SLL:  begin
        dec_aluop = ALUOPW'(3'b010);
        dec_srca  = 1'b1;
      end
      OP_SLT:  dec_aluop = ALUOPW'(3'b101);
      default: dec_alu = 1'b0;
    endcase
  end

  // Next-state and raw control outputs; PCWre marks the retiring cycle
  always_comb begin
    state_nxt = state;
    pcwre     = 1'b0;
    irwre     = 1'b0;
    insmemrw  = 1'b0;
    regwre    = 1'b0;
    regdst    = 2'b00;
    wrregdsrc = 1'b0;
    extsel    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 1'b0;
    aluop     = '0;
    pcsrc     = 2'b00;
    mrd       = 1'b0;
    mwr       = 1'b0;
    dbdatasrc = 1'b0;
    case (state)
      S_IF: begin
        irwre     = 1'b1;
        insmemrw  = 1'b1;
        state_nxt = S_ID;
      end
      S_ID: begin
        case (bus.opcode)
          OP_J: begin
            pcsrc     = 2'b11;
            pcwre     = 1'b1;
            state_nxt = S_IF;
          end
          OP_JR: begin
            pcsrc     = 2'b10;
            pcwre     = 1'b1;
            state_nxt = S_IF;
          end
          OP_JAL: begin
            pcsrc     = 2'b11;
            regwre    = 1'b1;
            regdst    = 2'b00;
            wrregdsrc = 1'b0;
            pcwre     = 1'b1;
            state_nxt = S_IF;
          end
          OP_HALT:      state_nxt = S_HALT;
          OP_BEQ:       state_nxt = S_EXE_BR;
          OP_LW, OP_SW: state_nxt = S_EXE_LS;
          default: begin
            if (dec_alu) begin
              state_nxt = S_EXE_AL;
            end else begin
              // undefined opcode retires as a nop
              pcwre     = 1'b1;
              state_nxt = S_IF;
            end
          end
        endcase
      end
      S_EXE_AL: begin
        aluop     = dec_aluop;
        alusrca   = dec_srca;
        alusrcb   = dec_srcb;
        extsel    = dec_ext;
        state_nxt = S_WB_AL;
      end
      S_WB_AL: begin
        aluop     = dec_aluop;
        alusrca   = dec_srca;
        alusrcb   = dec_srcb;
        extsel    = dec_ext;
        regwre    = 1'b1;
        wrregdsrc = 1'b1;
        dbdatasrc = 1'b0;
        regdst    = dec_rtype ? 2'b10 : 2'b01;
        pcwre     = 1'b1;
        state_nxt = S_IF;
      end
      S_EXE_BR: begin
        aluop     = ALUOPW'(3'b001);
        alusrcb   = 1'b0;
        extsel    = 1'b1;
        pcsrc     = bus.zero ? 2'b01 : 2'b00;
        pcwre     = 1'b1;
        state_nxt = S_IF;
      end
      S_EXE_LS: begin
        aluop     = ALUOPW'(3'b000);
        alusrcb   = 1'b1;
        extsel    = 1'b1;
        state_nxt = S_MEM;
      end
      S_MEM: begin
        if (bus.opcode == OP_LW) begin
          mrd       = 1'b1;
          state_nxt = S_WB_LD;
        end else begin
          mwr       = 1'b1;
          pcwre     = 1'b1;
          state_nxt = S_IF;
        end
      end
      S_WB_LD: begin
        regwre    = 1'b1;
        regdst    = 2'b01;
        wrregdsrc = 1'b1;
        dbdatasrc = 1'b1;
        pcwre     = 1'b1;
        state_nxt = S_IF;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // Write enables are suppressed while reset is held so an aborted
  // instruction leaves no side effects in PC, IR, regfile or memory.
  assign bus.PCWre     = pcwre  & RST;
  assign bus.IRWre     = irwre  & RST;
  assign bus.RegWre    = regwre & RST;
  assign bus.mRD       = mrd    & RST;
  assign bus.mWR       = mwr    & RST;
  assign bus.InsMemRW  = insmemrw;
  assign bus.RegDst    = regdst;
  assign bus.WrRegDSrc = wrregdsrc;
  assign bus.ExtSel    = extsel;
  assign bus.ALUSrcA   = alusrca;
  assign bus.ALUSrcB   = alusrcb;
  assign bus.ALUOp     = aluop;
  assign bus.PCSrc     = pcsrc;
  assign bus.DBDataSrc = dbdatasrc;

`ifdef CU_PERF_COUNT_EN
  // Performance counters: cycles outside HALT and retired instructions
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 1'b1;
      if (pcwre)           instr_cnt <= instr_cnt + 1'b1;
    end
  end
`else
  // no performance counters in this build
`endif

endmodule
